// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor: 2-bit saturating counter
// encodings, the counter reset value, and the PC field extraction helpers
// that both the fetch (lookup) side and the execute (update) side use.
// ---------------------------------------------------------------------------
package bp_pkg;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt_t;

  localparam bp_cnt_t BP_CNT_RESET = BP_WNT;

  // Table index: word-aligned PC bits just above the byte offset.
  // Returned zero-extended; the caller truncates it to INDEX_BITS.
  function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                           input int          index_bits);
    return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  // BTB tag: the PC bits immediately above the index field.
  function automatic logic [31:0] bp_tag(input logic [31:0] pc,
                                         input int          index_bits,
                                         input int          tag_bits);
    return (pc >> (index_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter
// Next-state logic for one 2-bit saturating branch counter.
// Ports:
//   cur      in  2  current counter value
//   taken    in  1  resolved outcome (count up when 1, down when 0)
//   force_st in  1  unconditional jump: jump straight to strongly taken
//   nxt      out 2  next counter value
// ---------------------------------------------------------------------------
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  input  logic       force_st,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (force_st) begin
      nxt = BP_ST;
    end else if (taken) begin
      case (cur)
        BP_SNT:  nxt = BP_WNT;
        BP_WNT:  nxt = BP_WT;
        default: nxt = BP_ST;
      endcase
    end else begin
      case (cur)
        BP_ST:   nxt = BP_WT;
        BP_WT:   nxt = BP_WNT;
        default: nxt = BP_SNT;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Dynamic branch predictor: untagged BHT of 2-bit saturating counters plus a
// tagged BTB sharing the same index, with saturating mispredict statistics.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   if_pc               fetch PC to look up
//   pred_hit            BTB entry valid and tag matches if_pc
//   pred_taken          predicted taken
//   pred_target         predicted next PC (BTB target or if_pc+4)
//   ex_valid            a branch/jump resolves this cycle
//   ex_is_jump          resolved instruction is JAL/JALR
//   ex_pc, ex_taken,    resolved PC, outcome and target
//   ex_target
//   ex_pred_taken,      prediction that travelled down the pipe with it
//   ex_pred_target
//   mispredict          flush request
//   redirect_pc         correct next PC for the resolved instruction
//   stat_branches       resolved-instruction count (saturating)
//   stat_mispredicts    mispredict count (saturating)
// ---------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int STAT_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  input  logic                 ex_valid,
  input  logic                 ex_is_jump,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic                 ex_pred_taken,
  input  logic [31:0]          ex_pred_target,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]          r_bht        [ENTRIES];
  logic [ENTRIES-1:0]  r_btb_valid;
  logic [TAG_BITS-1:0] r_btb_tag    [ENTRIES];
  logic [31:0]         r_btb_target [ENTRIES];
  logic [STAT_BITS-1:0] r_stat_branches;
  logic [STAT_BITS-1:0] r_stat_mispredicts;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0]   w_if_tag;
  logic [TAG_BITS-1:0]   w_ex_tag;
  logic                  w_hit;
  logic                  w_taken;
  logic                  w_mispredict;
  logic [1:0]            w_bht_nxt;

  assign w_if_idx = INDEX_BITS'(bp_index(if_pc, INDEX_BITS));
  assign w_ex_idx = INDEX_BITS'(bp_index(ex_pc, INDEX_BITS));
  assign w_if_tag = TAG_BITS'(bp_tag(if_pc, INDEX_BITS, TAG_BITS));
  assign w_ex_tag = TAG_BITS'(bp_tag(ex_pc, INDEX_BITS, TAG_BITS));

  // Lookup reads registered state only, so an update to the same index in
  // this cycle becomes visible on the next cycle (no bypass).
  assign w_hit   = r_btb_valid[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
  assign w_taken = w_hit && r_bht[w_if_idx][1];

  assign pred_hit    = w_hit;
  assign pred_taken  = w_taken;
  assign pred_target = w_taken ? r_btb_target[w_if_idx] : if_pc + 32'd4;

  assign w_mispredict = ex_valid &&
                        ((ex_pred_taken != ex_taken) ||
                         (ex_taken && (ex_pred_target != ex_target)));
  assign mispredict   = w_mispredict;
  assign redirect_pc  = ex_taken ? ex_target : ex_pc + 32'd4;

  bp_sat_counter u_sat_counter (
    .cur      (r_bht[w_ex_idx]),
    .taken    (ex_taken),
    .force_st (ex_is_jump),
    .nxt      (w_bht_nxt)
  );

  // BHT is untagged, so the counter trains on every resolve regardless of
  // whether the BTB holds this PC. Only taken outcomes allocate a BTB entry,
  // overwriting whatever aliased there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_bht[i] <= BP_CNT_RESET;
      end
      r_btb_valid <= '0;
    end else if (ex_valid) begin
      r_bht[w_ex_idx] <= w_bht_nxt;
      if (ex_taken) begin
        r_btb_valid[w_ex_idx] <= 1'b1;
      end
    end
  end

  // Tag and target payload are qualified by r_btb_valid and need no reset.
  always_ff @(posedge clk) begin
    if (ex_valid && ex_taken) begin
      r_btb_tag[w_ex_idx]    <= w_ex_tag;
      r_btb_target[w_ex_idx] <= ex_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (ex_valid && (r_stat_branches != '1)) begin
        r_stat_branches <= r_stat_branches + STAT_BITS'(1);
      end
      if (w_mispredict && (r_stat_mispredicts != '1)) begin
        r_stat_mispredicts <= r_stat_mispredicts + STAT_BITS'(1);
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor (4-bit statistics so saturation is
// reachable quickly). Expected values are queued as stimulus is applied and
// popped when the corresponding output is sampled.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   if_pc;
  logic          pred_hit;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          ex_valid;
  logic          ex_is_jump;
  logic [31:0]   ex_pc;
  logic          ex_taken;
  logic [31:0]   ex_target;
  logic          ex_pred_taken;
  logic [31:0]   ex_pred_target;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic [SB-1:0] stat_branches;
  logic [SB-1:0] stat_mispredicts;

  branch_predictor #(
    .INDEX_BITS (6),
    .TAG_BITS   (8),
    .STAT_BITS  (SB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_is_jump       (ex_is_jump),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_br   = 0;
  int   exp_mp   = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %h, no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic hit, input logic tk,
                      input logic [31:0] tgt);
    if_pc = pc;
    expect_val("pred_hit", 32'(hit));
    expect_val("pred_taken", 32'(tk));
    expect_val("pred_target", tgt);
    #1;
    check_next(32'(pred_hit));
    check_next(32'(pred_taken));
    check_next(pred_target);
  endtask

  task automatic check_stats();
    expect_val("stat_branches", 32'(exp_br));
    expect_val("stat_mispredicts", 32'(exp_mp));
    #1;
    check_next(32'(stat_branches));
    check_next(32'(stat_mispredicts));
  endtask

  // Drive one resolving instruction and check the combinational flush
  // outputs; the caller then clocks it in with tick_clear.
  task automatic drive_ex(input logic jump, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt,
                          input logic exp_mis, input logic [31:0] exp_redir);
    ex_valid       = 1'b1;
    ex_is_jump     = jump;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    expect_val("mispredict", 32'(exp_mis));
    expect_val("redirect_pc", exp_redir);
    #1;
    check_next(32'(mispredict));
    check_next(redirect_pc);
    if (exp_br < 15) exp_br++;
    if (exp_mis && exp_mp < 15) exp_mp++;
  endtask

  task automatic tick_clear();
    tick();
    ex_valid   = 1'b0;
    ex_is_jump = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    if_pc          = 32'h100;
    ex_valid       = 1'b0;
    ex_is_jump     = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    #3;

    // Reset state
    look(32'h100, 1'b0, 1'b0, 32'h104);
    check_stats();
    tick();
    tick();
    rst = 1'b0;

    // Train 0x100 taken -> 0x40 (WNT -> WT, BTB allocated)
    drive_ex(1'b0, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104, 1'b1, 32'h40);
    tick_clear();
    look(32'h100, 1'b1, 1'b1, 32'h40);
    check_stats();

    // Three not-taken: WT -> WNT -> SNT -> SNT, BTB entry retained
    drive_ex(1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h104);
    tick_clear();
    look(32'h100, 1'b1, 1'b0, 32'h104);
    drive_ex(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h104);
    tick_clear();
    look(32'h100, 1'b1, 1'b0, 32'h104);
    drive_ex(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h104);
    tick_clear();
    look(32'h100, 1'b1, 1'b0, 32'h104);
    check_stats();

    // One taken from SNT only reaches WNT
    drive_ex(1'b0, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104, 1'b1, 32'h40);
    tick_clear();
    look(32'h100, 1'b1, 1'b0, 32'h104);

    // ex_valid low: no flush, redirect still driven, no state change
    ex_pc = 32'h100; ex_taken = 1'b1; ex_target = 32'h40;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h104;
    expect_val("mispredict_idle", 32'h0);
    expect_val("redirect_idle", 32'h40);
    #1;
    check_next(32'(mispredict));
    check_next(redirect_pc);
    tick();
    look(32'h100, 1'b1, 1'b0, 32'h104);
    check_stats();

    // Aliasing: 0x200 shares index 0 with a different tag
    drive_ex(1'b0, 32'h200, 1'b1, 32'h80, 1'b0, 32'h204, 1'b1, 32'h80);
    tick_clear();
    look(32'h100, 1'b0, 1'b0, 32'h104);
    look(32'h200, 1'b1, 1'b1, 32'h80);
    // Not-taken keeps the BTB entry
    drive_ex(1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h204);
    tick_clear();
    look(32'h200, 1'b1, 1'b0, 32'h204);
    // Taken with wrong carried target only
    drive_ex(1'b0, 32'h200, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 32'h80);
    tick_clear();
    look(32'h200, 1'b1, 1'b1, 32'h80);
    // Correct taken prediction: no flush
    drive_ex(1'b0, 32'h200, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
    tick_clear();
    check_stats();

    // Mid-operation async reset between edges
    if_pc = 32'h200;
    ex_valid = 1'b1; ex_pc = 32'h200; ex_taken = 1'b1; ex_target = 32'h80;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h204;
    rst = 1'b1;
    exp_br = 0;
    exp_mp = 0;
    look(32'h200, 1'b0, 1'b0, 32'h204);
    check_stats();
    expect_val("mispredict_in_reset", 32'h1);
    expect_val("redirect_in_reset", 32'h80);
    #1;
    check_next(32'(mispredict));
    check_next(redirect_pc);
    ex_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Same-cycle collision at 0x100 from WNT: update not visible until next cycle
    drive_ex(1'b0, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104, 1'b1, 32'h40);
    look(32'h100, 1'b0, 1'b0, 32'h104);
    tick_clear();
    look(32'h100, 1'b1, 1'b1, 32'h40);
    // Counter was reset to WNT, so WT -> WNT now predicts not-taken
    drive_ex(1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h104);
    tick_clear();
    look(32'h100, 1'b1, 1'b0, 32'h104);

    // JAL forces strongly taken: one not-taken afterwards still predicts taken
    drive_ex(1'b1, 32'h308, 1'b1, 32'h500, 1'b0, 32'h30c, 1'b1, 32'h500);
    tick_clear();
    look(32'h308, 1'b1, 1'b1, 32'h500);
    drive_ex(1'b0, 32'h308, 1'b0, 32'h0, 1'b1, 32'h500, 1'b1, 32'h30c);
    tick_clear();
    look(32'h308, 1'b1, 1'b1, 32'h500);
    check_stats();

    // Statistics saturation at all-ones
    for (int i = 0; i < 20; i++) begin
      drive_ex(1'b0, 32'h400 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 32'h0,
               1'b1, 32'h404 + 32'(i * 4));
      tick_clear();
    end
    check_stats();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the pipelined RV32 core.
- Fetch side: looks up the fetch PC and returns a speculative taken/target decision.
- Execute side: receives the resolved outcome from the branch control unit (taken, target, jump) and updates its predictor state.
- Flags mispredicts and supplies the redirect PC.
- Structure: BHT of 2-bit saturating counters plus a tagged BTB, with mispredict statistics counters.

Parameters:
- INDEX_BITS, 6, log2 of entry count (BHT and BTB share index).
- TAG_BITS, 8, BTB tag width.
- STAT_BITS, 32, width of the statistics counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- if_pc  input  32  fetch PC.
- pred_hit  output  1  BTB valid and tag match for if_pc.
- pred_taken  output  1  predicted taken.
- pred_target  output  32  predicted next PC.
- ex_valid  input  1  a branch/jump resolves this cycle.
- ex_is_jump  input  1  resolved instruction is JAL/JALR.
- ex_pc  input  32  PC of the resolved instruction.
- ex_taken  input  1  actual outcome.
- ex_target  input  32  actual taken target.
- ex_pred_taken  input  1  prediction carried down the pipe.
- ex_pred_target  input  32  predicted target carried down the pipe.
- mispredict  output  1  flush request.
- redirect_pc  output  32  correct next PC.
- stat_branches  output  STAT_BITS  resolved-instruction count.
- stat_mispredicts  output  STAT_BITS  mispredict count.

Behaviour:
- Address fields:
  - idx = pc[INDEX_BITS+1:2].
  - tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- Lookup (zero latency, combinational from current state):
  - pred_hit = btb_valid[idx] && btb_tag[idx]==tag.
  - pred_taken = pred_hit && bht[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : if_pc+4 (mod 2^32).
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Update, at the clock edge when ex_valid=1:
  - ex_is_jump=1: bht[idx]<=11.
  - Otherwise, bht[idx] saturating +1 if ex_taken, saturating -1 if not.
  - BHT is untagged: the counter updates regardless of BTB hit.
  - BTB write only when ex_taken=1: valid<=1, tag<=ex tag, target<=ex_target. An aliasing entry is overwritten.
  - Not-taken never allocates or invalidates a BTB entry.
- Mispredict (combinational, asserted only when ex_valid=1):
  - mispredict = (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, always driven.
  - ex_valid=0: mispredict=0.
- Statistics:
  - stat_branches +1 per ex_valid cycle.
  - stat_mispredicts +1 per mispredict cycle.
  - Both saturate at all-ones (no wrap).
- Simultaneous lookup and update to the same idx: lookup returns pre-update state; the new state is visible the next cycle. No bypass.
- Reset (async, any time, including mid-training):
  - All bht <= 01, all btb_valid <= 0, stats <= 0.
  - Outputs immediately: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
  - mispredict/redirect_pc follow ex_* inputs combinationally.
  - btb_tag/btb_target need no reset.
- ex_* inputs are ignored for state when ex_valid=0.

Decomposition:
- Shared package bp_pkg:
  - Counter encodings BP_SNT/BP_WNT/BP_WT/BP_ST.
  - BP_CNT_RESET=BP_WNT.
  - Index/tag field extraction helpers.
- One sub-module, bp_sat_counter: 2-bit saturating next-state logic (inputs cur, taken, force_st; output nxt), instantiated once on the update path.

Test Plan:
- Reset, if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104. stat_branches=0, stat_mispredicts=0.
- Train: ex_valid=1, ex_pc=0x100, ex_taken=1, ex_target=0x40, ex_pred_taken=0 -> same cycle mispredict=1, redirect_pc=0x40. Next cycle with if_pc=0x100 -> pred_hit=1, pred_taken=1 (counter 10), pred_target=0x40. stat_mispredicts=1.
- Counter saturation: drive three not-taken updates at 0x100 (ex_pred_taken=1, then 0, 0) -> pred_taken=0 after the first. Counter reaches 00 and stays. pred_hit stays 1, pred_target=0x104. Mispredicts counted only where the prediction differed.
- Aliasing: train 0x100 taken to 0x40, then 0x200 taken to 0x80 (same idx 0, tags 1 vs 2) -> lookup 0x100 gives pred_hit=0, pred_target=0x104. Lookup 0x200 gives pred_target=0x80.
- Same-cycle collision: if_pc=0x100 while updating ex_pc=0x100 from WNT with taken -> this cycle pred_taken=0; next cycle pred_taken=1. JAL at 0x300 (ex_is_jump=1) -> counter=11 immediately.
- Mid-operation reset: after training, pulse rst between edges -> pred_hit drops to 0 without a clock edge, stats read 0. With STAT_BITS=4, 20 resolved branches -> stat_branches=15.
